// File: rtl/l1_cache_pkg.sv
// Shared L1 cache types and sizing constants: line data, line index, byte mask
// and the write-request bundle.
package l1_cache_pkg;

    localparam int L1_DATA_WIDTH = 1024;
    localparam int L1_ADDR_WIDTH = 8;
    localparam int L1_NUM_WMASKS = L1_DATA_WIDTH / 8;

    typedef logic [L1_DATA_WIDTH-1:0] l1_line_t;
    typedef logic [L1_ADDR_WIDTH-1:0] l1_idx_t;
    typedef logic [L1_NUM_WMASKS-1:0] l1_wmask_t;

    typedef struct packed {
        l1_idx_t   addr;
        l1_wmask_t wmask;
        l1_line_t  data;
    } l1_wr_req_t;

endpackage

// File: rtl/l1_rsp_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH so any
// depth (not only powers of two) is supported.
module l1_rsp_fifo
    import l1_cache_pkg::*;
#(
    parameter int WIDTH = L1_DATA_WIDTH,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && !full;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        pop_data = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/l1_sram_port_ctrl.sv
// L1 data-array port controller: registered write port 0, registered read port 1,
// credit-limited response FIFO. Optional counters under L1_SRAM_CTRL_PERF_EN.
module l1_sram_port_ctrl
    import l1_cache_pkg::*;
#(
    parameter int DATA_WIDTH = L1_DATA_WIDTH,
    parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
    parameter int NUM_WMASKS = DATA_WIDTH / 8,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WMASKS-1:0] wr_wmask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
`ifdef L1_SRAM_CTRL_PERF_EN
    output logic [31:0]           perf_rd_cnt,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_coll_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic                  coll;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rsp_pop;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;

    logic                  fair_q, fair_d;
    logic                  csb0_q, csb0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [CW-1:0]         cred_q, cred_d;

    // Handshake: a transfer happens on any rising clk edge where valid && ready;
    // valid must be held with stable payload until then, ready may toggle freely.
    always_comb begin
        coll     = wr_valid && rd_valid && (wr_addr == rd_addr);
        rsp_pop  = rsp_valid && rsp_ready;
        wr_ready = !(coll && fair_q);
        rd_ready = ((cred_q < CW'(RSP_DEPTH)) || rsp_pop) && !(coll && !fair_q);
        wr_fire  = wr_valid && wr_ready;
        rd_fire  = rd_valid && rd_ready;

        fair_d    = coll ? !fair_q : 1'b0;
        csb0_d    = !wr_fire;
        wmask0_d  = wmask0_q;
        addr0_d   = addr0_q;
        din0_d    = din0_q;
        csb1_d    = !rd_fire;
        addr1_d   = addr1_q;
        rd_pend_d = !csb1_q;
        cred_d    = cred_q + CW'(rd_fire) - CW'(rsp_pop);

        if (wr_fire) begin
            wmask0_d = wr_wmask;
            addr0_d  = wr_addr;
            din0_d   = wr_data;
        end
        if (rd_fire) begin
            addr1_d = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fair_q    <= 1'b0;
            csb0_q    <= 1'b1;
            wmask0_q  <= '0;
            addr0_q   <= '0;
            din0_q    <= '0;
            csb1_q    <= 1'b1;
            addr1_q   <= '0;
            rd_pend_q <= 1'b0;
            cred_q    <= '0;
        end else begin
            fair_q    <= fair_d;
            csb0_q    <= csb0_d;
            wmask0_q  <= wmask0_d;
            addr0_q   <= addr0_d;
            din0_q    <= din0_d;
            csb1_q    <= csb1_d;
            addr1_q   <= addr1_d;
            rd_pend_q <= rd_pend_d;
            cred_q    <= cred_d;
        end
    end

    assign sram_csb0   = csb0_q;
    assign sram_wmask0 = wmask0_q;
    assign sram_addr0  = addr0_q;
    assign sram_din0   = din0_q;
    assign sram_csb1   = csb1_q;
    assign sram_addr1  = addr1_q;
    assign rsp_valid   = !fifo_empty;

    // dout1 settles on the negedge after the array samples, so capture one edge later.
    l1_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data (sram_dout1),
        .pop       (rsp_pop),
        .pop_data  (rsp_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (cred_q <= CW'(RSP_DEPTH)) && (fifo_count <= cred_q));

`ifdef L1_SRAM_CTRL_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_coll_q, perf_coll_d;

    always_comb begin
        perf_rd_d   = perf_rd_q;
        perf_wr_d   = perf_wr_q;
        perf_coll_d = perf_coll_q;
        if (rd_fire && (perf_rd_q != '1))   perf_rd_d   = perf_rd_q + 32'd1;
        if (wr_fire && (perf_wr_q != '1))   perf_wr_d   = perf_wr_q + 32'd1;
        if (coll && (perf_coll_q != '1))    perf_coll_d = perf_coll_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q   <= '0;
            perf_wr_q   <= '0;
            perf_coll_q <= '0;
        end else begin
            perf_rd_q   <= perf_rd_d;
            perf_wr_q   <= perf_wr_d;
            perf_coll_q <= perf_coll_d;
        end
    end

    assign perf_rd_cnt   = perf_rd_q;
    assign perf_wr_cnt   = perf_wr_q;
    assign perf_coll_cnt = perf_coll_q;
`endif

endmodule

// File: tb/tb_l1_sram_port_ctrl.sv
// Bench for l1_sram_port_ctrl: behavioural SRAM, line-level reference memory,
// expected-response queue and per-scenario tasks.
module tb_l1_sram_port_ctrl;
    import l1_cache_pkg::*;

    localparam int DW = L1_DATA_WIDTH;
    localparam int AW = L1_ADDR_WIDTH;
    localparam int NM = L1_NUM_WMASKS;
    localparam int RD = 3;

    logic          clk;
    logic          rst_n;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [NM-1:0] wr_wmask;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          sram_csb0, sram_csb1;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0, sram_dout1;

    int n_checks = 0;
    int n_pass = 0;

    l1_sram_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_wmask(wr_wmask), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural SRAM ----------------
    logic [DW-1:0] sram_mem [256];
    logic          s_wp, s_rp;
    logic [AW-1:0] s_wa, s_ra;
    logic [NM-1:0] s_wm;
    logic [DW-1:0] s_wd;

    initial begin
        s_wp = 1'b0;
        s_rp = 1'b0;
    end

    always @(posedge clk) begin
        s_wp <= !sram_csb0;
        s_wa <= sram_addr0;
        s_wm <= sram_wmask0;
        s_wd <= sram_din0;
        s_rp <= !sram_csb1;
        s_ra <= sram_addr1;
    end

    always @(negedge clk) begin
        if (s_wp) begin
            for (int b = 0; b < NM; b++)
                if (s_wm[b]) sram_mem[s_wa][b*8 +: 8] = s_wd[b*8 +: 8];
        end
        if (s_rp) sram_dout1 = sram_mem[s_ra];
        else for (int j = 0; j < DW / 32; j++) sram_dout1[j*32 +: 32] = $urandom();
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_e;
    logic          m_fair, m_coll, m_pop, m_exp_rd, m_exp_wr;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_fair = 1'b0;
        end else begin
            m_coll   = wr_valid && rd_valid && (wr_addr == rd_addr);
            m_pop    = rsp_valid && rsp_ready;
            m_exp_wr = !(m_coll && m_fair);
            m_exp_rd = ((exp_q.size() < RD) || m_pop) && !(m_coll && !m_fair);
            n_checks++;
            if (wr_ready !== m_exp_wr)
                $display("FAIL wr_ready: got %b expected %b at %0t", wr_ready, m_exp_wr, $time);
            else n_pass++;
            n_checks++;
            if (rd_ready !== m_exp_rd)
                $display("FAIL rd_ready: got %b expected %b (outstanding %0d) at %0t",
                         rd_ready, m_exp_rd, exp_q.size(), $time);
            else n_pass++;
            if (!sram_csb0 && !sram_csb1) begin
                n_checks++;
                if (sram_addr0 === sram_addr1)
                    $display("FAIL port_same_addr: addr0 %h addr1 %h expected different at %0t",
                             sram_addr0, sram_addr1, $time);
                else n_pass++;
            end
            if (m_pop) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: rsp popped with no outstanding read at %0t", $time);
                end else begin
                    m_e = exp_q.pop_front();
                    if (rsp_data !== m_e)
                        $display("FAIL rsp_data: got low64 %h expected low64 %h at %0t",
                                 rsp_data[63:0], m_e[63:0], $time);
                    else n_pass++;
                end
            end
            if (rd_valid && rd_ready) exp_q.push_back(ref_mem[rd_addr]);
            if (wr_valid && wr_ready) begin
                for (int b = 0; b < NM; b++)
                    if (wr_wmask[b]) ref_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            end
            m_fair = m_coll ? !m_fair : 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        rsp_ready = 1'b1;
        idle();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        step();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", tag, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rsp_ready = 1'b1;
        wr_addr = '0; wr_wmask = '0; wr_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sram_csb0, sram_csb1} !== 2'b11)
            $display("FAIL reset_csb: got %b%b expected 11", sram_csb0, sram_csb1);
        else n_pass++;
        n_checks++;
        if (sram_wmask0 !== '0 || sram_addr0 !== '0 || sram_din0 !== '0 || sram_addr1 !== '0)
            $display("FAIL reset_regs: addr0 %h addr1 %h din0 low64 %h expected all zero",
                     sram_addr0, sram_addr1, sram_din0[63:0]);
        else n_pass++;
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        else n_pass++;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        d = {NM{8'hA5}};
        step(); wr_valid = 1'b1; wr_addr = 8'h05; wr_wmask = '1; wr_data = d;
        step(); wr_valid = 1'b0;
        step(); rd_valid = 1'b1; rd_addr = 8'h05;
        step(); rd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL wr_rd_lat1: rsp_valid %b expected 0", rsp_valid);
        else n_pass++;
        step(); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL wr_rd_lat2: rsp_valid %b expected 0", rsp_valid);
        else n_pass++;
        step(); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== d)
            $display("FAIL wr_rd_data: valid %b low64 %h expected 1 / %h", rsp_valid, rsp_data[63:0], d[63:0]);
        else n_pass++;
    endtask

    task automatic test_zero_mask();
        step(); wr_valid = 1'b1; wr_addr = 8'h05; wr_wmask = '0; wr_data = '0;
        step(); wr_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sram_csb0 !== 1'b0 || sram_wmask0 !== '0)
            $display("FAIL zero_mask_port: csb0 %b mask nonzero=%b expected 0/0", sram_csb0, |sram_wmask0);
        else n_pass++;
        step(); rd_valid = 1'b1; rd_addr = 8'h05;
        step(); rd_valid = 1'b0;
        step(); step(); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== {NM{8'hA5}})
            $display("FAIL zero_mask_data: valid %b low64 %h expected 1 / a5 repeat", rsp_valid, rsp_data[63:0]);
        else n_pass++;
    endtask

    task automatic test_collision();
        step(); wr_valid = 1'b1; wr_addr = 8'h10; wr_wmask = '1; wr_data = {NM{8'h11}};
        step(); wr_valid = 1'b0;
        step();
        step(); wr_valid = 1'b1; wr_data = {NM{8'h22}}; rd_valid = 1'b1; rd_addr = 8'h10;
        @(negedge clk);
        n_checks++;
        if (rd_ready !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL coll_first: rd_ready %b wr_ready %b expected 0/1", rd_ready, wr_ready);
        else n_pass++;
        step(); wr_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_ready !== 1'b1) $display("FAIL coll_retry: rd_ready %b expected 1", rd_ready);
        else n_pass++;
        step(); rd_valid = 1'b0;
        step(); step(); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== {NM{8'h22}})
            $display("FAIL coll_data: valid %b low64 %h expected 1 / 22 repeat", rsp_valid, rsp_data[63:0]);
        else n_pass++;
    endtask

    task automatic test_alternate();
        int nw, nr;
        nw = 0; nr = 0;
        step();
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 8'h20; rd_addr = 8'h20; wr_wmask = '1;
        for (int j = 0; j < DW / 32; j++) wr_data[j*32 +: 32] = $urandom();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (wr_ready !== (i % 2 == 0) || rd_ready !== (i % 2 == 1))
                $display("FAIL alt_turn%0d: wr_ready %b rd_ready %b expected %b/%b",
                         i, wr_ready, rd_ready, (i % 2 == 0), (i % 2 == 1));
            else n_pass++;
            if (wr_ready) nw++;
            if (rd_ready) nr++;
            step();
            if (i % 2 == 0) for (int j = 0; j < DW / 32; j++) wr_data[j*32 +: 32] = $urandom();
        end
        idle();
        n_checks++;
        if (nw != 3 || nr != 3) $display("FAIL alt_counts: writes %0d reads %0d expected 3/3", nw, nr);
        else n_pass++;
        drain("alt");
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            rd_valid = (i < 8);
            rd_addr  = AW'(i);
            @(negedge clk);
            if (i < 8) begin
                n_checks++;
                if (rd_ready !== 1'b1) $display("FAIL b2b_ready%0d: rd_ready %b expected 1", i, rd_ready);
                else n_pass++;
            end
            if (i >= 3) begin
                n_checks++;
                if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp%0d: rsp_valid %b expected 1", i, rsp_valid);
                else n_pass++;
            end
        end
        drain("b2b");
    endtask

    task automatic test_backpressure();
        int acc;
        logic have;
        logic [DW-1:0] held;
        acc = 0; have = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            rd_valid = (acc < 5);
            rd_addr  = AW'(8'h40 + acc);
            @(negedge clk);
            if (rd_valid && rd_ready) acc++;
            if (rsp_valid) begin
                if (have) begin
                    n_checks++;
                    if (rsp_data !== held)
                        $display("FAIL bp_stable: low64 %h expected held %h", rsp_data[63:0], held[63:0]);
                    else n_pass++;
                end else begin
                    held = rsp_data;
                    have = 1'b1;
                end
            end
        end
        n_checks++;
        if (acc != 3 || rd_ready !== 1'b0)
            $display("FAIL bp_accepts: accepted %0d rd_ready %b expected 3/0", acc, rd_ready);
        else n_pass++;
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rd_ready !== 1'b1) $display("FAIL bp_resume: rd_ready %b expected 1", rd_ready);
        else n_pass++;
        if (rd_valid && rd_ready) acc++;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            step();
            rd_valid = 1'b1;
            rd_addr  = AW'(8'h40 + acc);
            @(negedge clk);
            if (rd_ready) acc++;
        end
        n_checks++;
        if (acc != 5) $display("FAIL bp_total: accepted %0d expected 5", acc);
        else n_pass++;
        drain("bp");
    endtask

    task automatic test_reset_inflight();
        int acc;
        rsp_ready = 1'b1;
        step(); rd_valid = 1'b1; rd_addr = 8'h01;
        step(); rd_addr = 8'h02; wr_valid = 1'b1; wr_addr = 8'h77; wr_wmask = '0; wr_data = '1;
        step(); idle();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL rst_async: csb0 %b csb1 %b rsp_valid %b expected 1/1/0",
                     sram_csb0, sram_csb1, rsp_valid);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) $display("FAIL rst_stale%0d: rsp_valid %b expected 0", i, rsp_valid);
            else n_pass++;
        end
        acc = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            rd_valid = 1'b1;
            rd_addr  = AW'(8'h50 + acc);
            @(negedge clk);
            if (rd_ready) acc++;
        end
        n_checks++;
        if (acc != 3) $display("FAIL rst_credits: accepted %0d expected 3", acc);
        else n_pass++;
        drain("rst");
    endtask

    task automatic test_random();
        logic wf, rf;
        wf = 1'b0; rf = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!wr_valid || wf) begin
                wr_valid = ($urandom_range(0, 2) != 0);
                wr_addr  = AW'($urandom_range(0, 3));
                for (int j = 0; j < NM / 32; j++) wr_wmask[j*32 +: 32] = $urandom();
                for (int j = 0; j < DW / 32; j++) wr_data[j*32 +: 32] = $urandom();
            end
            if (!rd_valid || rf) begin
                rd_valid = ($urandom_range(0, 2) != 0);
                rd_addr  = AW'($urandom_range(0, 3));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            wf = wr_valid && wr_ready;
            rf = rd_valid && rd_ready;
        end
        drain("rand");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        sram_dout1 = '0;
        for (int a = 0; a < 256; a++) begin
            for (int j = 0; j < DW / 32; j++) sram_mem[a][j*32 +: 32] = $urandom();
            ref_mem[a] = sram_mem[a];
        end
        test_reset();
        test_write_read();
        test_zero_mask();
        test_collision();
        test_alternate();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

endmodule
